mem_stream_reader: RTL and testbench
====================================

// Module: mem_stream_reader
// PURPOSE
//  Read-side client for one port of mem_dual. On start, reads LENGTH consecutive words
//  from BASE (wrapping modulo DEPTH) and emits them as a valid/ready stream in address order.
//  Absorbs the memory's 1-cycle read latency with a 2-entry output FIFO, so backpressure
//  never drops or duplicates a word. Sits between a mem_dual port and a stream consumer.
// PARAMETERS
//  WIDTH   8      word width; must match mem_dual WIDTH
//  DEPTH   64     memory depth; must match mem_dual DEPTH; AW = `CLOG2(DEPTH)
// PORTS
//  clock        in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        1-cycle request; sampled only when busy=0
//  base_addr    in   AW       first address; sampled with start
//  length       in   AW+1     word count, 0..DEPTH; sampled with start
//  busy         out  1        transfer in progress
//  done         out  1        1-cycle pulse, transfer complete
//  mem_address  out  AW       to mem_dual address_x
//  mem_wren     out  1        to mem_dual wren_x; constant 0
//  mem_data     out  WIDTH    to mem_dual data_x; constant 0
//  mem_q        in   WIDTH    from mem_dual q_x; valid the cycle after the address is issued
//  out_data     out  WIDTH    stream data (FIFO head)
//  out_valid    out  1        stream valid
//  out_ready    in   1        stream ready; beat transfers when valid & ready
//  out_last     out  1        high with the final beat of a transfer
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy, done, out_valid, out_last = 0; FIFO empty;
//    in-flight flag 0; address and remaining counters 0. mem_address = 0.
//  - FSM states:
//    - IDLE: on start, latch base_addr and length, go to READ; busy=1 next cycle.
//      length=0 goes to FIN instead.
//    - READ: issue a read when remaining>0 and (fifo_count + inflight < 2, or a beat pops
//      this cycle). Issue means mem_address = addr counter this cycle; the counter then
//      increments mod DEPTH, remaining decrements, inflight=1 next cycle.
//      Go to DRAIN when the last read is issued.
//    - DRAIN: wait until inflight=0, FIFO empty and the last beat has popped, then go to FIN.
//    - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
//  - Capture: when inflight=1, mem_q is pushed into the FIFO at the next edge.
//    Push and pop may occur in the same cycle; the credit rule guarantees no overflow.
//  - Latency: start sampled at edge E0 -> first read issued in cycle after E0
//    -> out_valid=1 from the cycle after E0+2.
//  - Throughput: 1 beat/cycle while out_ready=1.
//  - out_data/out_valid are driven from FIFO registers only, never combinationally from mem_q.
//  - Valid/ready rules: once out_valid=1, out_data and out_last stay stable until accepted.
//    out_ready low stalls issue once 2 words are buffered or in flight.
//  - out_last: set only on the word read with remaining==1 at issue.
//  - Address wrap: DEPTH-1 is followed by 0. length=DEPTH reads every word exactly once.
//  - start while busy=1: ignored; no effect on the current transfer.
//  - Reset mid-transfer: all state cleared immediately; no done pulse; buffered words discarded.
//  - mem_wren and mem_data are constant 0 in every state.
// TESTING
//  - mem[k]=k+0x40. start, base=10, len=4, out_ready=1 -> 0x4A,0x4B,0x4C,0x4D on consecutive
//    cycles, first valid 3 cycles after start; out_last on 0x4D; done 1 cycle after.
//  - Same transfer, out_ready toggling 1,0,0,1,... -> identical 4-word sequence, no loss or
//    duplication; out_data stable while stalled.
//  - base=62, len=4 (DEPTH=64) -> mem_address 62,63,0,1; data 0x7E,0x7F,0x40,0x41.
//  - len=0 -> no out_valid; done pulses once; busy high for at most 2 cycles.
//    len=64 -> 64 beats, out_last only on beat 64.
//  - start with base=0, len=3 pulsed during a len=8 transfer -> ignored; exactly 8 beats, one done.
//  - rst_n low after 2 of 8 beats -> out_valid, busy, done = 0 at once, no done afterwards;
//    new start with len=2 afterwards completes normally.

Source files
------------

// File: rtl/mem_stream_reader_if.sv
// ----------------------------------------------------------------------------
// mem_stream_reader_if : RAM read-port and output-stream bundle for mem_stream_reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    mem_address;
  logic             mem_wren;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem_q;

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output mem_address,
    output mem_wren,
    output mem_data,
    input  mem_q,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address,
    input  mem_wren,
    input  mem_data,
    output mem_q,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_stream_reader.sv
// ----------------------------------------------------------------------------
// mem_stream_reader : streams LENGTH words from a 1-cycle-latency RAM port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] base_addr,
  input  logic [$clog2(DEPTH):0]   length,
  output logic                     busy,
  output logic                     done,
  mem_stream_reader_if.master      bus
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   REM_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]    addr;
  logic [AW:0]      remaining;
  logic             inflight;
  logic             inflight_last;

  logic [WIDTH-1:0] fifo_data [2];
  logic [1:0]       fifo_last;
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;

  logic             issue;
  logic             pop;
  logic             push;
  logic [1:0]       credit;
  logic [AW-1:0]    addr_inc;

  // Buffered plus in-flight words never exceed the two FIFO slots.
  assign push     = inflight;
  assign pop      = (count != 2'd0) && bus.out_ready;
  assign credit   = count + {1'b0, inflight};
  assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;

  assign bus.mem_address = addr;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;
  assign bus.out_data    = fifo_data[rd_ptr];
  assign bus.out_last    = fifo_last[rd_ptr];
  assign bus.out_valid   = (count != 2'd0);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? FIN : READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if ((remaining != '0) && ((credit < 2'd2) || pop)) begin
          issue = 1'b1;
          if (remaining == REM_ONE) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the final buffered beat is accepted.
        if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_last     <= '0;
      count         <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
      end
    end else begin
      if ((state == IDLE) && start) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr_inc;
        remaining <= remaining - REM_ONE;
      end

      inflight      <= issue;
      inflight_last <= issue && (remaining == REM_ONE);

      if (push) begin
        fifo_data[wr_ptr] <= bus.mem_q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_mem_stream_reader : directed checks of mem_stream_reader against a 64x8 RAM model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stream_reader;

  logic       clock;
  logic       rst_n;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;

  mem_stream_reader_if #(.WIDTH(8), .DEPTH(64)) bus ();

  mem_stream_reader #(.WIDTH(8), .DEPTH(64)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  logic [7:0] mem [64];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) bus.mem_q <= mem[bus.mem_address];

  int total = 0;
  int bad   = 0;

  int         cyc, ndone, done_cyc, first_valid, last_cyc, nlast;
  int         stall_err, busy_cyc, valid_seen, wr_err, seq_err;
  bit         stalled;
  logic [7:0] sd;
  logic       sl;
  logic [7:0] bdata [$];
  bit         blast [$];
  logic [5:0] alog  [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    cyc = 0; ndone = 0; done_cyc = -1; first_valid = -1; last_cyc = -1; nlast = 0;
    stall_err = 0; busy_cyc = 0; valid_seen = 0; wr_err = 0; stalled = 0;
    bdata.delete();
    blast.delete();
    for (int i = 0; i < 16; i++) alog[i] = '0;
  endtask

  // One cycle: drive inputs after negedge, record what the next posedge sees.
  task automatic tick(input bit rdy, input bit st, input logic [5:0] b, input logic [6:0] l);
    start = st; base_addr = b; length = l; bus.out_ready = rdy;
    #1;
    if (cyc < 16) alog[cyc] = bus.mem_address;
    if (bus.mem_wren !== 1'b0 || bus.mem_data !== 8'h00) wr_err++;
    if (bus.out_valid) begin
      valid_seen++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (stalled && (bus.out_data !== sd || bus.out_last !== sl)) stall_err++;
    stalled = bus.out_valid && !rdy;
    sd = bus.out_data;
    sl = bus.out_last;
    if (bus.out_valid && rdy) begin
      bdata.push_back(bus.out_data);
      blast.push_back(bus.out_last);
      if (bus.out_last) begin
        nlast++;
        last_cyc = cyc;
      end
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (busy) busy_cyc++;
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 8'(k + 8'h40);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_last",  {31'd0, bus.out_last}, 32'd0);
    chk("rst_addr",  {26'd0, bus.mem_address}, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    // base 10, len 4, always ready
    clear();
    tick(1, 1, 6'd10, 7'd4);
    repeat (9) tick(1, 0, 0, 0);
    chk("t1_nbeat", bdata.size(), 4);
    chk("t1_d0", {24'd0, bdata[0]}, 32'h4A);
    chk("t1_d1", {24'd0, bdata[1]}, 32'h4B);
    chk("t1_d2", {24'd0, bdata[2]}, 32'h4C);
    chk("t1_d3", {24'd0, bdata[3]}, 32'h4D);
    chk("t1_last3", {31'd0, blast[3]}, 32'd1);
    chk("t1_nlast", nlast, 1);
    chk("t1_first_valid", first_valid, 3);
    chk("t1_last_cyc", last_cyc, 6);
    chk("t1_ndone", ndone, 1);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_addr1", {26'd0, alog[1]}, 32'd10);
    chk("t1_wr_zero", wr_err, 0);

    // same transfer, ready 1,0,0,1,0,0,...
    clear();
    tick(1, 1, 6'd10, 7'd4);
    for (int i = 1; i < 25; i++) tick((i % 3) == 0, 0, 0, 0);
    chk("t2_nbeat", bdata.size(), 4);
    chk("t2_d0", {24'd0, bdata[0]}, 32'h4A);
    chk("t2_d1", {24'd0, bdata[1]}, 32'h4B);
    chk("t2_d2", {24'd0, bdata[2]}, 32'h4C);
    chk("t2_d3", {24'd0, bdata[3]}, 32'h4D);
    chk("t2_last3", {31'd0, blast[3]}, 32'd1);
    chk("t2_nlast", nlast, 1);
    chk("t2_stable", stall_err, 0);
    chk("t2_ndone", ndone, 1);

    // wrap: base 62, len 4
    clear();
    tick(1, 1, 6'd62, 7'd4);
    repeat (9) tick(1, 0, 0, 0);
    chk("t3_addr1", {26'd0, alog[1]}, 32'd62);
    chk("t3_addr2", {26'd0, alog[2]}, 32'd63);
    chk("t3_addr3", {26'd0, alog[3]}, 32'd0);
    chk("t3_addr4", {26'd0, alog[4]}, 32'd1);
    chk("t3_nbeat", bdata.size(), 4);
    chk("t3_d0", {24'd0, bdata[0]}, 32'h7E);
    chk("t3_d1", {24'd0, bdata[1]}, 32'h7F);
    chk("t3_d2", {24'd0, bdata[2]}, 32'h40);
    chk("t3_d3", {24'd0, bdata[3]}, 32'h41);

    // len 0
    clear();
    tick(1, 1, 6'd5, 7'd0);
    repeat (5) tick(1, 0, 0, 0);
    chk("t4_ndone", ndone, 1);
    chk("t4_no_valid", valid_seen, 0);
    chk("t4_busy_le2", {31'd0, busy_cyc <= 2}, 32'd1);

    // len 64 from base 0
    clear();
    tick(1, 1, 6'd0, 7'd64);
    repeat (75) tick(1, 0, 0, 0);
    chk("t5_nbeat", bdata.size(), 64);
    seq_err = 0;
    for (int i = 0; i < 64 && i < bdata.size(); i++) begin
      if (bdata[i] !== 8'(8'h40 + i)) seq_err++;
      if (blast[i] !== (i == 63)) seq_err++;
    end
    chk("t5_seq", seq_err, 0);
    chk("t5_nlast", nlast, 1);
    chk("t5_ndone", ndone, 1);

    // start pulsed while busy is ignored
    clear();
    tick(1, 1, 6'd20, 7'd8);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 1, 6'd0, 7'd3);
    repeat (20) tick(1, 0, 0, 0);
    chk("t6_nbeat", bdata.size(), 8);
    chk("t6_d0", {24'd0, bdata[0]}, 32'h54);
    chk("t6_d7", {24'd0, bdata[7]}, 32'h5B);
    chk("t6_nlast", nlast, 1);
    chk("t6_ndone", ndone, 1);

    // reset after two beats of an 8-word transfer
    clear();
    tick(1, 1, 6'd5, 7'd8);
    repeat (4) tick(1, 0, 0, 0);
    chk("t7_beats_before", bdata.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("t7_valid_rst", {31'd0, bus.out_valid}, 32'd0);
    chk("t7_busy_rst",  {31'd0, busy}, 32'd0);
    chk("t7_done_rst",  {31'd0, done}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    clear();
    repeat (6) tick(1, 0, 0, 0);
    chk("t7_no_done", ndone, 0);
    chk("t7_no_valid", valid_seen, 0);
    clear();
    tick(1, 1, 6'd30, 7'd2);
    repeat (9) tick(1, 0, 0, 0);
    chk("t7_nbeat", bdata.size(), 2);
    chk("t7_d0", {24'd0, bdata[0]}, 32'h5E);
    chk("t7_d1", {24'd0, bdata[1]}, 32'h5F);
    chk("t7_last1", {31'd0, blast[1]}, 32'd1);
    chk("t7_ndone", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
